// File: rtl/split_eval_sequencer_pkg.sv
// Shared types and constants for the split evaluation sequencer.
//   - split_state_e : sequencer FSM states
//   - DefNumSplits  : default size of the split checker bank
//   - DefEvalLat    : default checker latency (load to valid result)
//   - sel_width()   : width of a split index (at least 1)
//   - cnt_width()   : width of the latency counter, which holds EVAL_LAT-1
package split_eval_sequencer_pkg;

  localparam int unsigned DefNumSplits = 8;
  localparam int unsigned DefEvalLat   = 2;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWait,
    StCheck,
    StDone
  } split_state_e;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat > 1) ? int'($clog2(lat)) : 1;
  endfunction

endpackage

// File: rtl/split_next_idx.sv
// Lowest-set-bit finder over a split enable mask.
//   mask : candidate splits
//   idx  : index of the lowest set bit of mask (0 when mask is empty)
//   any  : mask has at least one bit set
module split_next_idx #(
  parameter int unsigned NUM_SPLITS = 8,
  parameter int unsigned SEL_W      = 3
) (
  input  logic [NUM_SPLITS-1:0] mask,
  output logic [SEL_W-1:0]      idx,
  output logic                  any
);

  always_comb begin
    idx = '0;
    any = |mask;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = NUM_SPLITS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/split_eval_sequencer.sv
// Sequences the split checker bank over one shared operand bus.
// Walks the enabled splits in ascending index order, gives each one EVAL_LAT cycles to
// produce its result, ANDs the results and stops at the first failing split.
//   clk, rst_n    : clock, asynchronous active-low reset
//   start_i       : begin a pass (accepted only when idle)
//   abort_i       : cancel a pass in progress
//   split_mask_i  : per-split enable, captured when start is accepted
//   split_x_i     : result of the selected split
//   split_sel_o   : index of the split under evaluation (held between passes)
//   split_load_o  : one-cycle operand load strobe for split_sel_o
//   busy_o        : pass in progress
//   done_o        : one-cycle end-of-pass strobe
//   sat_o         : pass result, held until the next completed pass
//   fail_idx_o    : first failing split, meaningful when done_o && !sat_o
//   aborted_o     : one-cycle strobe after a pass was cancelled
module split_eval_sequencer
  import split_eval_sequencer_pkg::*;
#(
  parameter int unsigned NUM_SPLITS = DefNumSplits,
  parameter int unsigned SEL_W      = sel_width(NUM_SPLITS),
  parameter int unsigned EVAL_LAT   = DefEvalLat
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [NUM_SPLITS-1:0] split_mask_i,
  input  logic                  split_x_i,
  output logic [SEL_W-1:0]      split_sel_o,
  output logic                  split_load_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  sat_o,
  output logic [SEL_W-1:0]      fail_idx_o,
  output logic                  aborted_o
);

  localparam int unsigned   CntW    = cnt_width(EVAL_LAT);
  localparam logic [CntW-1:0] CntLoad = CntW'(EVAL_LAT - 1);

  split_state_e          state_q, state_d;
  logic [NUM_SPLITS-1:0] mask_q, mask_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  sat_q, sat_d;
  logic [SEL_W-1:0]      fail_q, fail_d;
  logic                  aborted_q, aborted_d;

  logic [NUM_SPLITS-1:0] mask_rest;
  logic [NUM_SPLITS-1:0] pick_mask;
  logic [SEL_W-1:0]      pick_idx;
  logic                  pick_any;
  logic                  in_pass;

  // Mask with the split under evaluation retired.
  assign mask_rest = mask_q & ~(NUM_SPLITS'(1) << sel_q);

  // One finder serves both the first pick (from the incoming mask) and the next pick.
  assign pick_mask = (state_q == StIdle) ? split_mask_i : mask_rest;

  split_next_idx #(
    .NUM_SPLITS(NUM_SPLITS),
    .SEL_W     (SEL_W)
  ) u_next_idx (
    .mask(pick_mask),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign in_pass = (state_q == StLoad) || (state_q == StWait) || (state_q == StCheck);

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    fail_d    = fail_q;
    aborted_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mask_d = split_mask_i;
          if (pick_any) begin
            sel_d   = pick_idx;
            state_d = StLoad;
          end else begin
            sat_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      StLoad: begin
        cnt_d   = CntLoad;
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StCheck: begin
        if (!split_x_i) begin
          sat_d   = 1'b0;
          fail_d  = sel_q;
          state_d = StDone;
        end else begin
          mask_d = mask_rest;
          if (pick_any) begin
            sel_d   = pick_idx;
            state_d = StLoad;
          end else begin
            sat_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort wins over anything decided above, including a same-cycle check result.
    if (abort_i && in_pass) begin
      state_d   = StIdle;
      mask_d    = mask_q;
      sel_d     = sel_q;
      cnt_d     = cnt_q;
      sat_d     = sat_q;
      fail_d    = fail_q;
      aborted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mask_q    <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      fail_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      fail_q    <= fail_d;
      aborted_q <= aborted_d;
    end
  end

  assign split_sel_o  = sel_q;
  assign split_load_o = (state_q == StLoad);
  assign busy_o       = in_pass;
  assign done_o       = (state_q == StDone);
  assign sat_o        = sat_q;
  assign fail_idx_o   = fail_q;
  assign aborted_o    = aborted_q;

endmodule

// File: tb/tb_split_eval_sequencer.sv
module tb_split_eval_sequencer;

  localparam int unsigned NUM_SPLITS = 8;
  localparam int unsigned EVAL_LAT   = 2;
  localparam int unsigned SEL_W      = 3;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic                  start_i = 1'b0;
  logic                  abort_i = 1'b0;
  logic [NUM_SPLITS-1:0] split_mask_i = '0;
  logic                  split_x_i;
  logic [SEL_W-1:0]      split_sel_o;
  logic                  split_load_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  sat_o;
  logic [SEL_W-1:0]      fail_idx_o;
  logic                  aborted_o;

  split_eval_sequencer #(
    .NUM_SPLITS(NUM_SPLITS),
    .EVAL_LAT  (EVAL_LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .split_mask_i(split_mask_i),
    .split_x_i   (split_x_i),
    .split_sel_o (split_sel_o),
    .split_load_o(split_load_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .sat_o       (sat_o),
    .fail_idx_o  (fail_idx_o),
    .aborted_o   (aborted_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Checker bank model: latches the selected split on a load strobe; its result is
  // only valid from EVAL_LAT cycles after the load, and inverted (garbage) before.
  logic [NUM_SPLITS-1:0] resp_vec = '1;
  logic [SEL_W-1:0]      lat_sel = '0;
  int                    age = 1000;
  logic [SEL_W-1:0]      load_log[$];

  always @(posedge clk) begin
    if (split_load_o) begin
      lat_sel <= split_sel_o;
      age     <= 0;
      load_log.push_back(split_sel_o);
    end else if (age < 1000) begin
      age <= age + 1;
    end
  end

  assign split_x_i = (age >= int'(EVAL_LAT) - 1) ? resp_vec[lat_sel] : ~resp_vec[lat_sel];

  // Reference model of one pass.
  logic [SEL_W-1:0] exp_loads[$];
  logic             exp_sat = 1'b0;
  logic [SEL_W-1:0] exp_fail = '0;
  int               exp_cycles = 0;

  task automatic model_pass(input logic [NUM_SPLITS-1:0] m, input logic [NUM_SPLITS-1:0] r);
    exp_loads.delete();
    exp_sat = 1'b1;
    for (int i = 0; i < int'(NUM_SPLITS); i++) begin
      if (m[i]) begin
        exp_loads.push_back(SEL_W'(i));
        if (!r[i]) begin
          exp_sat  = 1'b0;
          exp_fail = SEL_W'(i);
          break;
        end
      end
    end
    exp_cycles = 1 + exp_loads.size() * int'(EVAL_LAT + 2);
  endtask

  function automatic string q2s(input logic [SEL_W-1:0] q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
    return s;
  endfunction

  function automatic bit loads_match();
    if (load_log.size() != exp_loads.size()) return 1'b0;
    foreach (exp_loads[i]) if (load_log[i] !== exp_loads[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Runs one pass from IDLE and checks it against the model.
  task automatic run_pass(input logic [NUM_SPLITS-1:0] m, input logic [NUM_SPLITS-1:0] r,
                          input bit hold_start, input string name);
    int n;
    bit busy_bad;
    model_pass(m, r);
    @(negedge clk);
    resp_vec     = r;
    split_mask_i = m;
    start_i      = 1'b1;
    load_log.delete();
    n        = 0;
    busy_bad = 1'b0;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (!hold_start) start_i = 1'b0;
      split_mask_i = NUM_SPLITS'($urandom);  // must not affect the captured mask
      if (done_o === 1'b1) break;
      if (busy_o !== 1'b1) busy_bad = 1'b1;
    end
    start_i = 1'b0;
    checks++;
    if (n !== exp_cycles)
      $display("FAIL %s done latency: got %0d cycles, expected %0d", name, n, exp_cycles);
    if (n !== exp_cycles) errors++;
    checks++;
    if (sat_o !== exp_sat) begin
      $display("FAIL %s sat: got %b, expected %b", name, sat_o, exp_sat);
      errors++;
    end
    checks++;
    if (fail_idx_o !== exp_fail) begin
      $display("FAIL %s fail_idx: got %0d, expected %0d", name, fail_idx_o, exp_fail);
      errors++;
    end
    checks++;
    if (!loads_match()) begin
      $display("FAIL %s loads: got [%s], expected [%s]", name, q2s(load_log), q2s(exp_loads));
      errors++;
    end
    checks++;
    if (busy_bad !== 1'b0 || busy_o !== 1'b0) begin
      $display("FAIL %s busy: gap during pass=%b, busy at done=%b, expected 0/0",
               name, busy_bad, busy_o);
      errors++;
    end
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      $display("FAIL %s after done: done=%b busy=%b, expected 0 0", name, done_o, busy_o);
      errors++;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({split_sel_o, split_load_o, busy_o, done_o, sat_o, fail_idx_o, aborted_o} !== '0) begin
      $display("FAIL reset outputs: got sel=%0d load=%b busy=%b done=%b sat=%b fail=%0d abt=%b, expected all 0",
               split_sel_o, split_load_o, busy_o, done_o, sat_o, fail_idx_o, aborted_o);
      errors++;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_o, done_o, split_load_o, aborted_o} !== 4'b0) begin
      $display("FAIL idle after reset: busy=%b done=%b load=%b abt=%b, expected 0",
               busy_o, done_o, split_load_o, aborted_o);
      errors++;
    end
  endtask

  task automatic test_all_pass();
    run_pass(8'hFF, 8'hFF, 1'b0, "all_pass");
  endtask

  task automatic test_early_fail();
    run_pass(8'b0010_1100, 8'b1101_1111, 1'b0, "early_fail");
  endtask

  task automatic test_vacuous();
    run_pass(8'h00, 8'h00, 1'b0, "vacuous");
  endtask

  // Abort while waiting on the second split; then a clean full pass.
  task automatic test_abort_wait();
    int n;
    bit saw_done;
    @(negedge clk);
    resp_vec = 8'hFF; split_mask_i = 8'hFF; start_i = 1'b1;
    load_log.delete();
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (load_log.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    abort_i = 1'b1;  // first WAIT cycle of the second split
    @(negedge clk);
    abort_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || aborted_o !== 1'b1 || done_o !== 1'b0) begin
      $display("FAIL abort_wait strobe: busy=%b aborted=%b done=%b, expected 0 1 0",
               busy_o, aborted_o, done_o);
      errors++;
    end
    checks++;
    if (sat_o !== exp_sat || fail_idx_o !== exp_fail) begin
      $display("FAIL abort_wait result kept: sat=%b fail=%0d, expected %b %0d",
               sat_o, fail_idx_o, exp_sat, exp_fail);
      errors++;
    end
    saw_done = 1'b0;
    @(negedge clk);
    checks++;
    if (aborted_o !== 1'b0) begin
      $display("FAIL abort_wait pulse width: aborted=%b, expected 0", aborted_o);
      errors++;
    end
    repeat (6) begin
      if (done_o !== 1'b0 || busy_o !== 1'b0) saw_done = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (saw_done !== 1'b0 || load_log.size() != 2) begin
      $display("FAIL abort_wait quiet: activity=%b loads=%0d, expected 0 2",
               saw_done, load_log.size());
      errors++;
    end
    run_pass(8'hFF, 8'hFF, 1'b0, "after_abort");
  endtask

  // Abort in the same cycle as a failing check: result registers must not move.
  task automatic test_abort_check();
    int n;
    @(negedge clk);
    resp_vec = 8'hFE; split_mask_i = 8'hFF; start_i = 1'b1;
    load_log.delete();
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (load_log.size() < 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (EVAL_LAT) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    checks++;
    if (aborted_o !== 1'b1 || done_o !== 1'b0 || sat_o !== exp_sat || fail_idx_o !== exp_fail) begin
      $display("FAIL abort_check: aborted=%b done=%b sat=%b fail=%0d, expected 1 0 %b %0d",
               aborted_o, done_o, sat_o, fail_idx_o, exp_sat, exp_fail);
      errors++;
    end
    @(negedge clk);
  endtask

  task automatic test_start_held();
    run_pass(8'b1001_0110, 8'hFF, 1'b1, "start_held");
  endtask

  // abort_i alone in IDLE does nothing; together with start_i the start wins.
  task automatic test_abort_idle();
    int n;
    @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    checks++;
    if (aborted_o !== 1'b0 || busy_o !== 1'b0) begin
      $display("FAIL abort_idle: aborted=%b busy=%b, expected 0 0", aborted_o, busy_o);
      errors++;
    end
    model_pass(8'h40, 8'hFF);
    resp_vec = 8'hFF; split_mask_i = 8'h40; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; abort_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || split_sel_o !== 3'd6) begin
      $display("FAIL start_with_abort: busy=%b sel=%0d, expected 1 6", busy_o, split_sel_o);
      errors++;
    end
    n = 1;
    while (done_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== exp_cycles || sat_o !== 1'b1) begin
      $display("FAIL start_with_abort done: cycles=%0d sat=%b, expected %0d 1", n, sat_o, exp_cycles);
      errors++;
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [NUM_SPLITS-1:0] m, r;
    for (int i = 0; i < 16; i++) begin
      m = NUM_SPLITS'($urandom);
      r = NUM_SPLITS'($urandom | $urandom | $urandom);
      run_pass(m, r, 1'b0, $sformatf("random%0d", i));
    end
  endtask

  // Asynchronous reset in the CHECK cycle of the second split.
  task automatic test_reset_mid_check();
    int n;
    @(negedge clk);
    resp_vec = 8'hFF; split_mask_i = 8'hFF; start_i = 1'b1;
    load_log.delete();
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (load_log.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (EVAL_LAT) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({split_sel_o, split_load_o, busy_o, done_o, sat_o, fail_idx_o, aborted_o} !== '0) begin
      $display("FAIL reset_mid_check: sel=%0d load=%b busy=%b done=%b sat=%b fail=%0d abt=%b, expected all 0",
               split_sel_o, split_load_o, busy_o, done_o, sat_o, fail_idx_o, aborted_o);
      errors++;
    end
    exp_sat  = 1'b0;
    exp_fail = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_pass(8'hFF, 8'hFF, 1'b0, "after_reset");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_all_pass();
    test_early_fail();
    test_vacuous();
    test_abort_wait();
    test_abort_check();
    test_start_held();
    test_abort_idle();
    test_random();
    test_reset_mid_check();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
